mips_irq_ctl: RTL
=================

# mips_irq_ctl

Parametrised memory-mapped interrupt controller for the mips789 device space. It generalises the fixed three-source timer/key interrupt logic to NCH sources. Each source has a synchroniser, a selectable edge or level mode, a pending latch, a mask bit and a vector register. A priority encoder and an IDLE/REQ/SERVICE state machine drive one vectored request to the core with an acknowledge and end-of-interrupt handshake.

## Interface
- NCH, 4, number of interrupt sources (1..16).
- BASE_ADDR, 32'h0000_3000, byte address of register 0; word-aligned.
- SYNC_STAGES, 2, flip-flop stages on each irq_src bit (>=2).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- din  in  32  store data from the core.
- addr  in  32  byte address from the core.
- mem_ctl  in  4  memory op code; only `DMEM_SW` (write) and `DMEM_LW` (read) are decoded, all other codes are ignored.
- dout  out  32  registered read data.
- irq_src  in  NCH  asynchronous interrupt sources.
- irq_req_o  out  1  registered interrupt request to the core.
- irq_addr_o  out  32  handler vector; valid while irq_req_o=1.
- irq_ack_i  in  1  core has taken the vector; one-cycle pulse.

## Operation
- Register map, byte offsets from BASE_ADDR (word access only):
  - 0x00 CTRL: bit0 = global enable GEN.
  - 0x04 MASK[NCH-1:0]: 1 = channel enabled.
  - 0x08 PEND: read returns pending bits; write clears each bit written as 1 (W1C).
  - 0x0C MODE[NCH-1:0]: 1 = rising edge, 0 = level.
  - 0x10 ACTIVE, read-only: bit31 = in SERVICE, bits3:0 = channel being serviced.
  - 0x14 EOI: a write of any value ends service.
  - 0x40+4*i VEC[i]: 32-bit handler address for channel i.
- Reads of unmapped offsets, and any cycle without a decoded LW, return dout=0.
- Unused bits read as 0.
- Synchroniser: each irq_src bit passes SYNC_STAGES flops, giving s[i]. One more flop gives s_d[i]. The edge condition is s & ~s_d.
- Pending, edge mode: set by an edge, cleared by a PEND W1C or by an ack of that channel. If a set and a clear hit the same cycle, the set wins.
- Pending, level mode: PEND[i] = s[i]. W1C and ack have no effect.
- Eligible set = PEND & MASK. The winner is the lowest-index eligible channel.
- States:
  - IDLE: if GEN=1 and the eligible set is non-empty, latch the winner into cur and VEC[winner] into irq_addr_o, then go to REQ.
  - REQ: irq_req_o=1. On irq_ack_i, clear PEND[cur] (edge mode only) and go to SERVICE. If GEN or MASK[cur] drops before the ack, withdraw the request, go to IDLE, and keep PEND.
  - SERVICE: irq_req_o=0 and no new request is raised (no nesting). A write to EOI returns to IDLE.
- irq_ack_i outside REQ is ignored.
- An EOI write outside SERVICE is ignored.
- A VEC[cur] write during REQ does not change irq_addr_o, which holds its latched value.

## Timing
- Reset (rst=0 at a clock edge) sets:
  - dout=0, irq_req_o=0, irq_addr_o=0;
  - CTRL, MASK, PEND, MODE and every VEC to 0;
  - the synchroniser and s_d to 0;
  - state IDLE.
- Reset applies in any state, including REQ and SERVICE. No request survives it.
- Register writes take effect at the clock edge where the SW is presented.
- Read data appears on dout one cycle after the LW cycle.
- irq_src rise to PEND set: SYNC_STAGES+1 cycles (edge mode).
- PEND set to irq_req_o=1: 1 cycle when in IDLE and eligible.
- irq_ack_i in cycle t: irq_req_o=0 and PEND bit cleared at t+1; ACTIVE bit31=1 from t+1.
- EOI write in cycle t: state IDLE at t+1. A still-eligible channel raises irq_req_o at t+2.
- The minimum gap between consecutive requests is 2 cycles after EOI.

## Test plan
- Reset state: hold rst=0 for 3 cycles, then LW every register -> all read 0, irq_req_o=0, irq_addr_o=0.
- Single edge interrupt:
  - Setup: NCH=4, VEC[2]=0x0000_0400, MODE=0xF, MASK=0x4, CTRL=1.
  - Stimulus: pulse irq_src[2].
  - Required: PEND=0x4 after 3 cycles; irq_req_o=1 with irq_addr_o=0x400 one cycle later.
  - Then: ack -> PEND=0 and ACTIVE=0x8000_0002; EOI -> IDLE with no re-request.
- Priority:
  - Stimulus: raise irq_src[1] and irq_src[3] on the same cycle, all masked on, with VEC[1]=0x100 and VEC[3]=0x300.
  - Required: first vector 0x100; after ack+EOI, second vector 0x300.
- Level mode and withdraw:
  - Stimulus: MODE[0]=0, hold irq_src[0]=1, then clear CTRL.0 before the ack.
  - Required: irq_req_o drops the next cycle while PEND[0] stays 1. Re-setting GEN re-raises the request.
- W1C race:
  - Stimulus: in edge mode, an edge on channel 0 lands in the same cycle as a PEND write of 0x1.
  - Required: PEND[0]=1 afterwards.
- Reset mid-service:
  - Stimulus: assert rst=0 in SERVICE and in REQ.
  - Required: state IDLE, irq_req_o=0, PEND=0, ACTIVE=0 on the next cycle.

Source files
------------

// File: rtl/mips_irq_ctl.sv
// mips_irq_ctl: memory-mapped vectored interrupt controller for the mips789
// device space. NCH asynchronous sources are synchronised, latched as pending
// (edge or level mode), masked and priority encoded. One vectored request at a
// time goes to the core through an IDLE/REQ/SERVICE state machine with an
// acknowledge and an end-of-interrupt handshake.
//
// Handshake: irq_req_o is a registered level that stays high with a stable
// irq_addr_o until the core pulses irq_ack_i for one cycle (taken) or until
// GEN/MASK[cur] drops (withdrawn). After the ack no new request is raised
// until software writes EOI. irq_ack_i outside REQ and EOI writes outside
// SERVICE have no effect.
module mips_irq_ctl #(
  parameter int          NCH         = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [3:0]  DMEM_SW     = 4'd5,
  parameter logic [3:0]  DMEM_LW     = 4'd6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    din,
  input  logic [31:0]    addr,
  input  logic [3:0]     mem_ctl,
  output logic [31:0]    dout,
  input  logic [NCH-1:0] irq_src,
  output logic           irq_req_o,
  output logic [31:0]    irq_addr_o,
  input  logic           irq_ack_i,
  output logic [1:0]     dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [4:0] NCH_W = 5'(NCH);

  // Register file
  logic           ctrl_q, ctrl_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] mode_q, mode_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [31:0]    vec_q [NCH];
  logic [31:0]    dout_q, dout_d;

  // Synchroniser chain and its one-cycle delayed copy
  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] s_d_q;
  logic [NCH-1:0] s;

  // State machine registers
  state_t         state_q;
  logic [3:0]     cur_q;
  logic           irq_req_q;
  logic [31:0]    irq_addr_q;

  // Bus decode
  logic [31:0]    off;
  logic           in_win;
  logic           wr_en, rd_en;
  logic           sel_vec;
  logic [3:0]     reg_idx;
  logic           wr_ctrl, wr_mask, wr_pend, wr_mode, wr_eoi;

  // Interrupt datapath
  logic [NCH-1:0] pend_eff;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] cur_oh;
  logic [NCH-1:0] edge_set;
  logic [NCH-1:0] w1c_clr;
  logic [NCH-1:0] ack_clr;
  logic           ack_take;
  logic           cur_mask_d;
  logic           any_elig;
  logic [3:0]     win;
  logic [31:0]    win_vec;
  logic [31:0]    rd_data;

  assign s = sync_q[SYNC_STAGES-1];

  // Word-aligned hit inside the 128-byte register window
  assign off     = addr - BASE_ADDR;
  assign in_win  = (off[31:7] == 25'd0) && (off[1:0] == 2'b00);
  assign wr_en   = (mem_ctl == DMEM_SW) && in_win;
  assign rd_en   = (mem_ctl == DMEM_LW) && in_win;
  assign sel_vec = off[6];
  assign reg_idx = off[5:2];

  assign wr_ctrl = wr_en && !sel_vec && (reg_idx == 4'd0);
  assign wr_mask = wr_en && !sel_vec && (reg_idx == 4'd1);
  assign wr_pend = wr_en && !sel_vec && (reg_idx == 4'd2);
  assign wr_mode = wr_en && !sel_vec && (reg_idx == 4'd3);
  assign wr_eoi  = wr_en && !sel_vec && (reg_idx == 4'd5);

  // Level channels follow the synchronised input directly; edge channels use the latch
  assign pend_eff = pend_q | (s & ~mode_q);
  assign elig     = pend_eff & mask_q;
  assign any_elig = |elig;
  assign ack_take = (state_q == S_REQ) && irq_ack_i;

  // One-hot of the channel in flight, used for ack clearing and mask-drop detection
  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cur_q == 4'(i)) cur_oh[i] = 1'b1;
    end
  end

  // Lowest-index eligible channel wins; its vector is fetched alongside
  always_comb begin
    win     = 4'd0;
    win_vec = 32'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) win = 4'(i);
    end
    for (int i = 0; i < NCH; i++) begin
      if (win == 4'(i)) win_vec = vec_q[i];
    end
  end

  // Next-state of the control registers and the edge pending latch
  always_comb begin
    ctrl_d = ctrl_q;
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_ctrl) ctrl_d = din[0];
    if (wr_mask) mask_d = din[NCH-1:0];
    if (wr_mode) mode_d = din[NCH-1:0];
    edge_set = s & ~s_d_q & mode_q;
    w1c_clr  = wr_pend ? din[NCH-1:0] : '0;
    ack_clr  = ack_take ? cur_oh : '0;
    // A new edge beats a same-cycle clear; level channels keep the latch at 0
    pend_d   = ((pend_q & ~w1c_clr & ~ack_clr) | edge_set) & mode_q;
    cur_mask_d = |(mask_d & cur_oh);
  end

  // Read multiplexer; anything unmapped reads as zero
  always_comb begin
    rd_data = 32'd0;
    if (!sel_vec) begin
      case (reg_idx)
        4'd0: rd_data = {31'd0, ctrl_q};
        4'd1: rd_data = {{(32-NCH){1'b0}}, mask_q};
        4'd2: rd_data = {{(32-NCH){1'b0}}, pend_eff};
        4'd3: rd_data = {{(32-NCH){1'b0}}, mode_q};
        4'd4: rd_data = (state_q == S_SERVICE) ? {1'b1, 27'd0, cur_q} : 32'd0;
        default: rd_data = 32'd0;
      endcase
    end else if ({1'b0, reg_idx} < NCH_W) begin
      for (int i = 0; i < NCH; i++) begin
        if (reg_idx == 4'(i)) rd_data = vec_q[i];
      end
    end
    dout_d = rd_en ? rd_data : 32'd0;
  end

  // Input synchroniser plus the delayed copy used for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d_q <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d_q <= s;
    end
  end

  // Software-visible registers and read data
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q <= 1'b0;
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
      dout_q <= 32'd0;
      for (int i = 0; i < NCH; i++) vec_q[i] <= 32'd0;
    end else begin
      ctrl_q <= ctrl_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      dout_q <= dout_d;
      for (int i = 0; i < NCH; i++) begin
        if (wr_en && sel_vec && (reg_idx == 4'(i))) vec_q[i] <= din;
      end
    end
  end

  // Request state machine with registered request and vector outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cur_q      <= 4'd0;
      irq_req_q  <= 1'b0;
      irq_addr_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_q && any_elig) begin
            cur_q      <= win;
            irq_addr_q <= win_vec;
            irq_req_q  <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack in the same cycle as a GEN/MASK drop still counts as taken
          if (irq_ack_i) begin
            irq_req_q <= 1'b0;
            state_q   <= S_SERVICE;
          end else if (!ctrl_d || !cur_mask_d) begin
            irq_req_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_SERVICE: begin
          irq_req_q <= 1'b0;
          if (wr_eoi) state_q <= S_IDLE;
        end
        default: begin
          irq_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign dout        = dout_q;
  assign irq_req_o   = irq_req_q;
  assign irq_addr_o  = irq_addr_q;
  assign dbg_state_o = state_q;

endmodule
